// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared types, limits and config validity rule for the clock divider bank
package clock_gen_pkg;
   typedef enum logic {IDLE, RUN} ch_state_e;
   localparam int unsigned MIN_PERIOD = 2;
   localparam int unsigned MIN_HIGH   = 1;
   function automatic logic cfg_ok(int unsigned ch, int unsigned nch, int unsigned n, int unsigned h);
      return ch < nch && n >= MIN_PERIOD && h >= MIN_HIGH && h < n;
   endfunction
endpackage

// File: rtl/clock_channel.sv
// clock_channel: one divider channel; wr_en loads a pre-validated config, pending/clk_out/tick/busy report status
module clock_channel
   import clock_gen_pkg::*;
#(
   parameter int DIV_WIDTH      = 16,
   parameter int DEFAULT_PERIOD = 20,
   parameter int DEFAULT_HIGH   = 10
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 wr_en,
   input  logic [DIV_WIDTH-1:0] wr_period,
   input  logic [DIV_WIDTH-1:0] wr_high,
   output logic                 pending,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 busy
);
   ch_state_e state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, per_q, per_d, high_q, high_d, sh_per_q, sh_per_d, sh_high_q, sh_high_d;
   logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_d     = per_q;
      high_d    = high_q;
      sh_per_d  = sh_per_q;
      sh_high_d = sh_high_q;
      pend_d    = pend_q;
      clk_d     = 1'b0;
      tick_d    = 1'b0;
      // a pending config is applied at every period boundary, and also on the idle cycle after a
      // disabling boundary so a write landing in that boundary never stays stuck in the shadow
      if (state_q == IDLE) begin
         if (pend_q) begin
            per_d  = sh_per_q;
            high_d = sh_high_q;
            pend_d = 1'b0;
         end
         if (wr_en) begin
            per_d  = wr_period;
            high_d = wr_high;
         end
         if (enable) begin
            state_d = RUN;
            cnt_d   = '0;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
         end
      end else if (cnt_q == per_q - DIV_WIDTH'(1)) begin
         cnt_d   = '0;
         state_d = enable ? RUN : IDLE;
         clk_d   = enable;
         tick_d  = enable;
         if (pend_q) begin
            per_d  = sh_per_q;
            high_d = sh_high_q;
            pend_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
         clk_d = cnt_d < high_q;
      end
      // ready is low while pending, so this never collides with the apply above
      if (wr_en && state_q == RUN) begin
         sh_per_d  = wr_period;
         sh_high_d = wr_high;
         pend_d    = 1'b1;
      end
   end
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         per_q     <= DIV_WIDTH'(DEFAULT_PERIOD);
         high_q    <= DIV_WIDTH'(DEFAULT_HIGH);
         sh_per_q  <= DIV_WIDTH'(DEFAULT_PERIOD);
         sh_high_q <= DIV_WIDTH'(DEFAULT_HIGH);
         pend_q    <= 1'b0;
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         per_q     <= per_d;
         high_q    <= high_d;
         sh_per_q  <= sh_per_d;
         sh_high_q <= sh_high_d;
         pend_q    <= pend_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
      end
   end
   assign pending = pend_q;
   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign busy    = state_q == RUN;
endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: CHANNELS programmable dividers; cfg_* is a valid/ready config port, cfg_error flags rejected writes, clk_out/tick/busy per channel
module clock_divider_bank
   import clock_gen_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int DIV_WIDTH      = 16,
   parameter int DEFAULT_PERIOD = 20,
   parameter int DEFAULT_HIGH   = 10
) (
   input  logic                                            clk_in,
   input  logic                                            reset,
   input  logic [CHANNELS-1:0]                             enable,
   input  logic                                            cfg_valid,
   output logic                                            cfg_ready,
   input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
   input  logic [DIV_WIDTH-1:0]                            cfg_period,
   input  logic [DIV_WIDTH-1:0]                            cfg_high,
   output logic                                            cfg_error,
   output logic [CHANNELS-1:0]                             clk_out,
   output logic [CHANNELS-1:0]                             tick,
   output logic [CHANNELS-1:0]                             busy
);
   logic [CHANNELS-1:0] pend, wr;
   logic ok, acc, err_q;
   // out-of-range channel numbers match no entry and so leave ready high
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++) if (int'(cfg_ch) == i && pend[i]) cfg_ready = 1'b0;
   end
   assign ok  = cfg_ok(32'(cfg_ch), CHANNELS, 32'(cfg_period), 32'(cfg_high));
   assign acc = cfg_valid && cfg_ready;
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else err_q <= acc && !ok;
   end
   assign cfg_error = err_q;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign wr[c] = acc && ok && int'(cfg_ch) == c;
      clock_channel #(
         .DIV_WIDTH(DIV_WIDTH),
         .DEFAULT_PERIOD(DEFAULT_PERIOD),
         .DEFAULT_HIGH(DEFAULT_HIGH)
      ) u_ch (
         .clk_in(clk_in),
         .reset(reset),
         .enable(enable[c]),
         .wr_en(wr[c]),
         .wr_period(cfg_period),
         .wr_high(cfg_high),
         .pending(pend[c]),
         .clk_out(clk_out[c]),
         .tick(tick[c]),
         .busy(busy[c])
      );
   end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed and random stimulus checked against a phase-based reference model
module tb_clock_divider_bank;
   logic clk_in = 1'b0;
   logic reset;
   logic [3:0] enable;
   logic cfg_valid, cfg_ready, cfg_error;
   logic [1:0] cfg_ch;
   logic [15:0] cfg_period, cfg_high;
   logic [3:0] clk_out, tick, busy;
   logic cv3, rdy3, err3;
   logic [1:0] ch3;
   logic [15:0] p3 = 16'd8, h3 = 16'd4;
   logic [2:0] en3 = 3'b000, clk3, tick3, busy3;

   always #5 clk_in = ~clk_in;

   clock_divider_bank dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_error(cfg_error),
      .clk_out(clk_out), .tick(tick), .busy(busy)
   );

   clock_divider_bank #(.CHANNELS(3)) dut3 (
      .clk_in(clk_in), .reset(reset), .enable(en3), .cfg_valid(cv3), .cfg_ready(rdy3),
      .cfg_ch(ch3), .cfg_period(p3), .cfg_high(h3), .cfg_error(err3),
      .clk_out(clk3), .tick(tick3), .busy(busy3)
   );

   int n_checks = 0, n_pass = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // model: each channel knows how many cycles into its period it is
   int m_n[4], m_h[4], m_sn[4], m_sh[4], m_ph[4];
   bit m_pend[4], m_run[4], m_err, m_acc;

   function automatic bit m_ready(int ch);
      return !(ch < 4 && m_pend[ch]);
   endfunction

   task automatic m_reset();
      for (int c = 0; c < 4; c++) begin
         m_n[c] = 20; m_h[c] = 10; m_sn[c] = 20; m_sh[c] = 10;
         m_ph[c] = 0; m_pend[c] = 0; m_run[c] = 0;
      end
      m_err = 0; m_acc = 0;
   endtask

   task automatic m_step();
      bit ok, wr;
      ok = int'(cfg_ch) < 4 && int'(cfg_period) >= 2 && int'(cfg_high) >= 1 && cfg_high < cfg_period;
      m_acc = cfg_valid && m_ready(int'(cfg_ch));
      m_err = m_acc && !ok;
      for (int c = 0; c < 4; c++) begin
         wr = m_acc && ok && int'(cfg_ch) == c;
         if (m_run[c]) begin
            m_ph[c]++;
            if (m_ph[c] == m_n[c]) begin
               if (m_pend[c]) begin m_n[c] = m_sn[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
               m_ph[c] = 0;
               m_run[c] = enable[c];
            end
            if (wr) begin m_sn[c] = int'(cfg_period); m_sh[c] = int'(cfg_high); m_pend[c] = 1; end
         end else begin
            if (m_pend[c]) begin m_n[c] = m_sn[c]; m_h[c] = m_sh[c]; m_pend[c] = 0; end
            if (wr) begin m_n[c] = int'(cfg_period); m_h[c] = int'(cfg_high); end
            if (enable[c]) begin m_run[c] = 1; m_ph[c] = 0; end
         end
      end
   endtask

   task automatic step();
      logic [3:0] ec, et, eb;
      #1 check("cfg_ready", cfg_ready, m_ready(int'(cfg_ch)));
      @(posedge clk_in);
      m_step();
      @(negedge clk_in);
      for (int c = 0; c < 4; c++) begin
         ec[c] = m_run[c] && m_ph[c] < m_h[c];
         et[c] = m_run[c] && m_ph[c] == 0;
         eb[c] = m_run[c];
      end
      check("clk_out", clk_out, ec);
      check("tick", tick, et);
      check("busy", busy, eb);
      check("cfg_error", cfg_error, m_err);
   endtask

   task automatic run(int k);
      repeat (k) step();
   endtask

   task automatic wr(int ch, int n, int h);
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(n); cfg_high = 16'(h);
      for (int i = 0; i < 64; i++) begin
         step();
         if (m_acc) break;
      end
      check("wr_accept", m_acc, 1'b1);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ph(int c, int p);
      for (int i = 0; i < 64; i++) begin
         if (m_run[c] && m_ph[c] == p) break;
         step();
      end
      check("wait_phase", m_ph[c], p);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
      cv3 = 1'b0; ch3 = '0;
      m_reset();
      repeat (2) @(negedge clk_in);
      check("rst_clk_out", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_error", cfg_error, 0);
      reset = 1'b0;
      // defaults on ch0
      enable[0] = 1'b1;
      run(45);
      // reconfigure a running channel, then a second write that must stall
      enable[1] = 1'b1;
      wait_ph(1, 7);
      wr(1, 5, 2);
      wr(1, 6, 3);
      run(30);
      // invalid writes
      wr(0, 1, 1); run(2);
      wr(0, 8, 0); run(2);
      wr(0, 8, 8); run(2);
      // out-of-range channel on a 3-channel bank
      cv3 = 1'b1; ch3 = 2'd3;
      #1 check("oor_ready", rdy3, 1'b1);
      step();
      check("oor_error", err3, 1'b1);
      cv3 = 1'b0;
      step();
      check("oor_error_clear", err3, 1'b0);
      check("oor_ready_after", rdy3, 1'b1);
      check("oor_clk_out", clk3, 3'b000);
      // disable mid-period, then restart
      enable[2] = 1'b1;
      wait_ph(2, 3);
      enable[2] = 1'b0;
      run(25);
      enable[2] = 1'b1;
      run(25);
      // async reset mid-high with a pending config
      enable[3] = 1'b1;
      wait_ph(3, 2);
      wr(3, 6, 3);
      wait_ph(3, 5);
      check("pre_rst_high", clk_out[3], 1'b1);
      #2 reset = 1'b1;
      #1 check("async_rst_clk_out", clk_out, 0);
      check("async_rst_busy", busy, 0);
      m_reset();
      enable = '0;
      @(negedge clk_in);
      reset = 1'b0;
      cfg_ch = 2'd3;
      enable[3] = 1'b1;
      run(45);
      // all channels at clk_in/2, aligned
      enable = '0;
      run(25);
      for (int c = 0; c < 4; c++) wr(c, 2, 1);
      enable = 4'hF;
      for (int i = 0; i < 10; i++) begin
         step();
         check("aligned", clk_out == 4'hF || clk_out == 4'h0, 1'b1);
      end
      // random traffic
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 4; c++) if ($urandom_range(15) == 0) enable[c] = ~enable[c];
         if (!cfg_valid || m_acc) begin
            cfg_valid = $urandom_range(3) == 0;
            cfg_ch = 2'($urandom_range(3));
            cfg_period = 16'($urandom_range(12, 1));
            cfg_high = 16'($urandom_range(int'(cfg_period), 0));
         end
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
